// File: rtl/burst_sram_arbiter.sv
// -----------------------------------------------------------------------------
// burst_sram_arbiter
//
// Shares one single-port SRAM between two independent burst masters. A master
// posts a burst (start address, beats-1, direction). Bursts are arbitrated
// round-robin and then issued as one SRAM access per clock with an
// incrementing, wrapping address. Write data is taken from the owning
// requester. Read data comes back one cycle later, tagged with the owner ID.
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   req_valid[1:0] per-requester burst request
//   req_ready[1:0] combinational accept, one-hot or zero, only in IDLE
//   req_write[1:0] per-requester direction, 1 = write
//   req_addr       per-requester start address, slice i*ADDR_WIDTH
//   req_len        per-requester beats-1, slice i*LEN_WIDTH
//   wr_data        per-requester write data for the current beat
//   beat_ack[1:0]  one-hot pulse to the owner on every issued beat
//   sram_*         SRAM control, address and write data
//   sram_rd_data   SRAM read data, valid one cycle after sram_rden
//   rd_valid/rd_id/rd_data  returned read beat with its owner
//   busy           high while a burst is being issued
// -----------------------------------------------------------------------------
module burst_sram_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [1:0]              req_write,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*LEN_WIDTH-1:0]  req_len,
   input  logic [2*DATA_WIDTH-1:0] wr_data,
   output logic [1:0]              beat_ack,
   output logic                    sram_wren,
   output logic                    sram_rden,
   output logic [ADDR_WIDTH-1:0]   sram_addr,
   output logic [DATA_WIDTH-1:0]   sram_wr_data,
   input  logic [DATA_WIDTH-1:0]   sram_rd_data,
   output logic                    rd_valid,
   output logic                    rd_id,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  owner_q, owner_d;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  rd_id_q, rd_id_d;

   logic                  grant_valid;
   logic                  grant_id;

   // Round-robin: a lone request wins outright; on a tie, the requester that
   // was not served last wins. Only req_valid is examined, so X on the other
   // fields of an idle requester cannot reach the grant.
   always_comb begin
      grant_valid = |req_valid;
      if (req_valid == 2'b11) grant_id = ~last_grant_q;
      else                    grant_id = req_valid[1];
   end

   always_comb begin
      // NOTE: every always_comb output takes a default first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      write_d      = write_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      // Read data is returned in the cycle after the SRAM read strobe.
      rd_valid_d   = (state_q == BURST) && !write_q;
      rd_id_d      = owner_q;

      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               state_d      = BURST;
               owner_d      = grant_id;
               last_grant_d = grant_id;
               write_d      = req_write[grant_id];
               addr_d       = grant_id ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                       : req_addr[ADDR_WIDTH-1:0];
               cnt_d        = grant_id ? req_len[2*LEN_WIDTH-1:LEN_WIDTH]
                                       : req_len[LEN_WIDTH-1:0];
            end
         end
         BURST: begin
            // The address is not advanced on the last beat, so sram_addr
            // holds the final address through the following IDLE cycles.
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d  = cnt_q - 1'b1;
               addr_d = addr_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         cnt_q        <= '0;
         rd_valid_q   <= 1'b0;
         rd_id_q      <= 1'b0;
      end else begin
         // NOTE: state updates are non-blocking, so every flop samples the
         // values from before the edge regardless of statement order.
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         rd_valid_q   <= rd_valid_d;
         rd_id_q      <= rd_id_d;
      end
   end

   assign busy      = (state_q == BURST);
   // rst is included because state_q is already IDLE during reset and a held
   // request would otherwise appear accepted.
   assign req_ready = (!rst && !busy && grant_valid) ? (grant_id ? 2'b10 : 2'b01)
                                                     : 2'b00;
   assign beat_ack  = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

   assign sram_wren    = busy && write_q;
   assign sram_rden    = busy && !write_q;
   assign sram_addr    = addr_q;
   assign sram_wr_data = !sram_wren ? '0
                       : owner_q    ? wr_data[2*DATA_WIDTH-1:DATA_WIDTH]
                                    : wr_data[DATA_WIDTH-1:0];

   assign rd_valid = rd_valid_q;
   assign rd_id    = rd_id_q;
   // Pass-through of the SRAM data, forced to zero while no beat is returning
   // so that nothing leaks out during reset.
   assign rd_data  = rd_valid_q ? sram_rd_data : '0;

endmodule

// File: tb/tb_burst_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_burst_sram_arbiter
//
// Directed bench for burst_sram_arbiter. A behavioural SRAM sits on the SRAM
// port. A table of single-requester bursts checks each beat against
// hand-computed addresses and data. Hand-written sequences cover
// arbitration order, turnaround timing and reset in the middle of a burst.
// -----------------------------------------------------------------------------
module tb_burst_sram_arbiter;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int LW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      req_valid, req_ready, req_write, beat_ack;
   logic [2*AW-1:0] req_addr;
   logic [2*LW-1:0] req_len;
   logic [2*DW-1:0] wr_data;
   logic            sram_wren, sram_rden, rd_valid, rd_id, busy;
   logic [AW-1:0]   sram_addr;
   logic [DW-1:0]   sram_wr_data, sram_rd_data, rd_data;

   burst_sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_len(req_len), .wr_data(wr_data),
      .beat_ack(beat_ack),
      .sram_wren(sram_wren), .sram_rden(sram_rden), .sram_addr(sram_addr),
      .sram_wr_data(sram_wr_data), .sram_rd_data(sram_rd_data),
      .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural single-port SRAM with one-cycle read latency.
   logic [DW-1:0] mem [256];
   always @(posedge clk) begin
      if (sram_wren) mem[sram_addr] <= sram_wr_data;
      if (sram_rden) sram_rd_data <= mem[sram_addr];
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (!busy) begin
            done = 1'b1;
            break;
         end
      end
      check("idle_timeout", {31'd0, done}, 32'd1);
   endtask

   typedef struct {
      logic        id;
      logic        wr;
      logic [7:0]  addr;
      logic [3:0]  len;
      logic [31:0] base;      // data of beat 0; beat k carries base+k
      int          exp_beats;
      logic [7:0]  exp_end;   // address of the last beat, held afterwards
   } vec_t;

   vec_t vecs[8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 1'b1, 8'h10, 4'd3,  32'hA0, 4,  8'h13};
      vecs[1] = '{1'b0, 1'b0, 8'h10, 4'd3,  32'hA0, 4,  8'h13};
      vecs[2] = '{1'b1, 1'b1, 8'hFE, 4'd3,  32'hB0, 4,  8'h01};
      vecs[3] = '{1'b1, 1'b0, 8'hFE, 4'd3,  32'hB0, 4,  8'h01};
      vecs[4] = '{1'b0, 1'b1, 8'h40, 4'd0,  32'hC0, 1,  8'h40};
      vecs[5] = '{1'b1, 1'b1, 8'h80, 4'd15, 32'hD0, 16, 8'h8F};
      vecs[6] = '{1'b0, 1'b0, 8'h80, 4'd15, 32'hD0, 16, 8'h8F};
      vecs[7] = '{1'b1, 1'b0, 8'h40, 4'd0,  32'hC0, 1,  8'h40};

      // Reset with both requesters asking: every output must stay zero.
      rst       = 1'b1;
      req_valid = 2'b11;
      req_write = 2'b00;
      req_addr  = {8'h38, 8'h30};
      req_len   = {4'd1, 4'd1};
      wr_data   = '0;
      #12;
      check("reset_outputs",
            {11'd0, req_ready, beat_ack, sram_wren, sram_rden, busy, rd_valid, rd_id, sram_addr},
            32'd0);
      check("reset_rd_data", rd_data, 32'd0);

      // Simultaneous requests straight after reset: req0 wins first.
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("arb_first", {30'd0, req_ready}, 32'd1);
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         #1;
         check("burst0_ack", {30'd0, beat_ack}, 32'd1);
         check("held_ready", {30'd0, req_ready}, 32'd0);
      end
      // Turnaround cycle: idle, req1 accepted, last read of req0 returning.
      @(negedge clk);
      #1;
      check("turnaround_idle", {31'd0, busy}, 32'd0);
      check("arb_second", {30'd0, req_ready}, 32'd2);
      check("rd_last_owner0", {30'd0, rd_valid, rd_id}, 32'd2);
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      check("burst1_ack", {30'd0, beat_ack}, 32'd2);
      check("burst1_addr0", {24'd0, sram_addr}, 32'h38);
      @(negedge clk);
      #1;
      check("burst1_addr1", {24'd0, sram_addr}, 32'h39);
      check("rd_owner1", {30'd0, rd_valid, rd_id}, 32'd3);
      // Next tie after req1 was served goes to req0, then to req1.
      @(negedge clk);
      req_valid = 2'b11;
      #1;
      check("rr_after_req1", {30'd0, busy, req_ready[0]}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b00;
      wait_idle();
      req_valid = 2'b11;
      #1;
      check("rr_after_req0", {30'd0, req_ready}, 32'd2);
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b00;
      wait_idle();

      // Reset during beat 2 of an 8-beat read by req0.
      req_valid    = 2'b01;
      req_addr[7:0] = 8'h20;
      req_len[3:0]  = 4'd7;
      #1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b11;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("mid_beat2_addr", {24'd0, sram_addr}, 32'h22);
      rst = 1'b1;
      #1;
      check("mid_rst_outputs",
            {11'd0, req_ready, beat_ack, sram_wren, sram_rden, busy, rd_valid, rd_id, sram_addr},
            32'd0);
      check("mid_rst_rd_data", rd_data, 32'd0);
      @(negedge clk);
      #1;
      check("no_rd_after_rst", {30'd0, rd_valid, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("grant_after_rst", {30'd0, req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b00;
      wait_idle();

      // Table of single-requester bursts, checked beat by beat.
      for (int v = 0; v < 8; v++) begin
         int id;
         int beats;
         bit got;
         id = int'(vecs[v].id);
         @(negedge clk);
         req_valid                = 2'b00;
         req_valid[id]            = 1'b1;
         req_write[id]            = vecs[v].wr;
         req_addr[id*AW +: AW]    = vecs[v].addr;
         req_len[id*LW +: LW]     = vecs[v].len;
         wr_data                  = {2{32'hDEAD_BEEF}};
         wr_data[id*DW +: DW]     = vecs[v].base;
         #1;
         got = 1'b0;
         for (int c = 0; c < 20; c++) begin
            if (req_ready[id]) begin
               got = 1'b1;
               break;
            end
            @(negedge clk);
            #1;
         end
         check($sformatf("v%0d_ready", v), {30'd0, req_ready}, (id == 1) ? 32'd2 : 32'd1);
         @(posedge clk);
         beats = 0;
         for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            req_valid            = 2'b00;
            wr_data[id*DW +: DW] = vecs[v].base + k;
            #1;
            if (!vecs[v].wr && k > 0) begin
               check($sformatf("v%0d_rd_tag%0d", v, k - 1), {30'd0, rd_valid, rd_id},
                     {30'd0, 1'b1, vecs[v].id});
               check($sformatf("v%0d_rd_data%0d", v, k - 1), rd_data, vecs[v].base + k - 1);
            end
            if (!busy) break;
            beats++;
            check($sformatf("v%0d_ack%0d", v, k), {30'd0, beat_ack}, (id == 1) ? 32'd2 : 32'd1);
            check($sformatf("v%0d_dir%0d", v, k), {30'd0, sram_wren, sram_rden},
                  vecs[v].wr ? 32'd2 : 32'd1);
            check($sformatf("v%0d_addr%0d", v, k), {24'd0, sram_addr},
                  {24'd0, 8'(vecs[v].addr + k)});
            if (vecs[v].wr)
               check($sformatf("v%0d_wdata%0d", v, k), sram_wr_data, vecs[v].base + k);
         end
         check($sformatf("v%0d_beats", v), beats, vecs[v].exp_beats);
         check($sformatf("v%0d_end_addr", v), {24'd0, sram_addr}, {24'd0, vecs[v].exp_end});
         check($sformatf("v%0d_idle_strobes", v), {30'd0, sram_wren, sram_rden}, 32'd0);
         @(negedge clk);
         #1;
         check($sformatf("v%0d_rd_quiet", v), {31'd0, rd_valid}, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
